// File: rtl/twofish_pkg.sv
// Shared definitions for the Twofish round engine.
//   - Block and word widths and the default round count.
//   - FSM state encoding.
//   - 32-bit rotate helpers.
//   - The Twofish g() function for a 128-bit key (two S-box words).
// Byte convention: byte 0 of every 32-bit word (g input, g output and the
// S-box words) is bits [31:24]. In g(), the first key XOR uses s1 and the
// second uses s0.
package twofish_pkg;

  localparam int TF_ROUNDS = 16;
  localparam int TF_BLK_W  = 128;
  localparam int TF_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tf_state_e;

  // Nibble tables for the q0/q1 permutations. Element 0 is the leftmost digit.
  localparam logic [0:15][3:0] Q0_T0 = 64'h817D6F320B59ECA4;
  localparam logic [0:15][3:0] Q0_T1 = 64'hECB81235F4A6709D;
  localparam logic [0:15][3:0] Q0_T2 = 64'hBA5E6D90C8F32471;
  localparam logic [0:15][3:0] Q0_T3 = 64'hD7F4126E9B3085CA;
  localparam logic [0:15][3:0] Q1_T0 = 64'h28BDF76E31940AC5;
  localparam logic [0:15][3:0] Q1_T1 = 64'h1E2B4C376DA5F908;
  localparam logic [0:15][3:0] Q1_T2 = 64'h4C75169A0ED82B3F;
  localparam logic [0:15][3:0] Q1_T3 = 64'hB951C3DE647F208A;

  function automatic logic [TF_WORD_W-1:0] rol32(input logic [TF_WORD_W-1:0] x, input int n);
    return (x << n) | (x >> (TF_WORD_W - n));
  endfunction

  function automatic logic [TF_WORD_W-1:0] ror32(input logic [TF_WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (TF_WORD_W - n));
  endfunction

  function automatic logic [3:0] ror4(input logic [3:0] v);
    return {v[0], v[3:1]};
  endfunction

  // sel=0 selects q0, sel=1 selects q1.
  function automatic logic [7:0] q_perm(input logic [7:0] x, input logic sel);
    logic [3:0] a1, b1, a2, b2, a3, b3, a4, b4;
    a1 = x[7:4] ^ x[3:0];
    b1 = x[7:4] ^ ror4(x[3:0]) ^ {x[4], 3'b000};
    a2 = sel ? Q1_T0[a1] : Q0_T0[a1];
    b2 = sel ? Q1_T1[b1] : Q0_T1[b1];
    a3 = a2 ^ b2;
    b3 = a2 ^ ror4(b2) ^ {a2[0], 3'b000};
    a4 = sel ? Q1_T2[a3] : Q0_T2[a3];
    b4 = sel ? Q1_T3[b3] : Q0_T3[b3];
    return {b4, a4};
  endfunction

  // GF(2^8) multiply, field polynomial x^8+x^6+x^5+x^3+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h69) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [TF_WORD_W-1:0] g_func(input logic [TF_WORD_W-1:0] x,
                                                  input logic [TF_WORD_W-1:0] s0,
                                                  input logic [TF_WORD_W-1:0] s1);
    logic [7:0] y0, y1, y2, y3, z0, z1, z2, z3;
    y0 = q_perm(q_perm(q_perm(x[31:24], 1'b0) ^ s1[31:24], 1'b0) ^ s0[31:24], 1'b1);
    y1 = q_perm(q_perm(q_perm(x[23:16], 1'b1) ^ s1[23:16], 1'b0) ^ s0[23:16], 1'b0);
    y2 = q_perm(q_perm(q_perm(x[15:8],  1'b0) ^ s1[15:8],  1'b1) ^ s0[15:8],  1'b1);
    y3 = q_perm(q_perm(q_perm(x[7:0],   1'b1) ^ s1[7:0],   1'b1) ^ s0[7:0],   1'b0);
    // MDS matrix multiply
    z0 = y0 ^ gf_mul(y1, 8'hEF) ^ gf_mul(y2, 8'h5B) ^ gf_mul(y3, 8'h5B);
    z1 = gf_mul(y0, 8'h5B) ^ gf_mul(y1, 8'hEF) ^ gf_mul(y2, 8'hEF) ^ y3;
    z2 = gf_mul(y0, 8'hEF) ^ gf_mul(y1, 8'h5B) ^ y2 ^ gf_mul(y3, 8'hEF);
    z3 = gf_mul(y0, 8'hEF) ^ y1 ^ gf_mul(y2, 8'hEF) ^ gf_mul(y3, 8'h5B);
    return {z0, z1, z2, z3};
  endfunction

endpackage

// File: rtl/twofish_f_function.sv
// Twofish F function (combinational): two g() evaluations, PHT and subkey add.
// Ports:
//   r0, r1         : current R0/R1 words
//   s0, s1         : S-box key words
//   k_even, k_odd  : round subkeys K[2r+8], K[2r+9]
//   f0, f1         : F outputs, all adds modulo 2^32
module twofish_f_function
  import twofish_pkg::*;
(
  input  logic [TF_WORD_W-1:0] r0,
  input  logic [TF_WORD_W-1:0] r1,
  input  logic [TF_WORD_W-1:0] s0,
  input  logic [TF_WORD_W-1:0] s1,
  input  logic [TF_WORD_W-1:0] k_even,
  input  logic [TF_WORD_W-1:0] k_odd,
  output logic [TF_WORD_W-1:0] f0,
  output logic [TF_WORD_W-1:0] f1
);

  logic [TF_WORD_W-1:0] t0, t1;

  always_comb begin
    t0 = g_func(r0, s0, s1);
    t1 = g_func(rol32(r1, 8), s0, s1);
    f0 = t0 + t1 + k_even;
    f1 = t0 + {t1[TF_WORD_W-2:0], 1'b0} + k_odd;
  end

endmodule

// File: rtl/twofish_round_engine.sv
// Iterative Twofish round engine: one Feistel round per clock on a 128-bit block.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : block input handshake, in_data = {R0,R1,R2,R3}
//   s0, s1              : S-box key words, held stable for the whole block
//   rk_idx              : round index to the key store (0 outside RUN)
//   rk_even, rk_odd     : K[2r+8], K[2r+9], combinational reply to rk_idx
//   out_valid/out_ready : block output handshake, out_data = {R2,R3,R0,R1}
//   state_dbg           : current FSM state
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE
// and out_data holds there until out_ready is seen.
module twofish_round_engine
  import twofish_pkg::*;
#(
  parameter int ROUNDS = TF_ROUNDS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [TF_BLK_W-1:0]  in_data,
  input  logic [TF_WORD_W-1:0] s0,
  input  logic [TF_WORD_W-1:0] s1,
  output logic [3:0]           rk_idx,
  input  logic [TF_WORD_W-1:0] rk_even,
  input  logic [TF_WORD_W-1:0] rk_odd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TF_BLK_W-1:0]  out_data,
  output logic [1:0]           state_dbg
);

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  tf_state_e            state_q, state_d;
  logic [3:0]           round_q, round_d;
  logic [TF_WORD_W-1:0] r0_q, r1_q, r2_q, r3_q;
  logic [TF_WORD_W-1:0] r0_d, r1_d, r2_d, r3_d;
  logic [TF_WORD_W-1:0] f0, f1;

  twofish_f_function u_f (
    .r0     (r0_q),
    .r1     (r1_q),
    .s0     (s0),
    .s1     (s1),
    .k_even (rk_even),
    .k_odd  (rk_odd),
    .f0     (f0),
    .f1     (f1)
  );

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    r0_d      = r0_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    r3_d      = r3_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rk_idx    = 4'd0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          r0_d    = in_data[127:96];
          r1_d    = in_data[95:64];
          r2_d    = in_data[63:32];
          r3_d    = in_data[31:0];
          round_d = 4'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        rk_idx = round_q;
        // New R0/R1 are the mixed halves; old R0/R1 move to R2/R3.
        r0_d   = ror32(r2_q ^ f0, 1);
        r1_d   = rol32(r3_q, 1) ^ f1;
        r2_d   = r0_q;
        r3_d   = r1_q;
        if (round_q == LAST_ROUND) begin
          round_d = 4'd0;
          state_d = DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The final swap is undone here, so out_data is {R2,R3,R0,R1}.
  assign out_data  = {r2_q, r3_q, r0_q, r1_q};
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      r0_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
    end
  end

endmodule
